// File: rtl/cla_pkg.sv
// Shared types for the sequential CLA adder.
// The slice width is fixed at four bits.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cla_state_t;

    localparam int CLA_SLICE_W = 4;

endpackage

// File: rtl/cla_seq_adder_ctrl_slice.sv
// 4-bit carry lookahead slice and its g/p preprocessing.
// Purely combinational; reused every RUN cycle.
module cla_pre_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_g,
    output logic [3:0] o_p
);

    assign o_g = i_a & i_b;
    assign o_p = i_a | i_b;

endmodule

module cla_slice_4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c,
    output logic       o_c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    cla_pre_4 u_pre (
        .i_a (i_a),
        .i_b (i_b),
        .o_g (g),
        .o_p (p)
    );

    // Flattened lookahead equations; every carry depends only on g, p and i_c.
    always_comb begin
        c[0] = i_c;
        c[1] = g[0] | (p[0] & i_c);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & i_c);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & i_c);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & i_c);
    end

    assign o_s  = i_a ^ i_b ^ c[3:0];
    assign o_c  = c[4];
    assign o_c3 = c[3];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder walking one 4-bit CLA slice LSB first.
// Valid/ready on both sides; result held in DONE until taken.
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int NSLICE = WIDTH / CLA_SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if (WIDTH % CLA_SLICE_W != 0) begin : g_bad_width
        $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4");
    end

    cla_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [CLA_SLICE_W-1:0] sl_a;
    logic [CLA_SLICE_W-1:0] sl_b;
    logic [CLA_SLICE_W-1:0] sl_s;
    logic                   sl_c;
    logic                   sl_c3;

    assign sl_a = a_q[{cnt, 2'b00} +: CLA_SLICE_W];
    assign sl_b = b_q[{cnt, 2'b00} +: CLA_SLICE_W];

    cla_slice_4 u_slice (
        .i_a  (sl_a),
        .i_b  (sl_b),
        .i_c  (carry),
        .o_s  (sl_s),
        .o_c  (sl_c),
        .o_c3 (sl_c3)
    );

    // Controller FSM: accept, walk the slices, then hold the result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_b;
                        carry   <= i_cin;
                        cnt     <= '0;
                        o_sum   <= '0;
                        o_cout  <= 1'b0;
                        o_ovf   <= 1'b0;
                        o_ready <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    o_sum[{cnt, 2'b00} +: CLA_SLICE_W] <= sl_s;
                    carry <= sl_c;
                    if (cnt == LAST) begin
                        o_cout  <= sl_c;
                        o_ovf   <= sl_c3 ^ sl_c;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl at WIDTH=16.
// Directed table, corner sequences and random ops vs a 17-bit model.
module tb_cla_seq_adder_ctrl;

    localparam int W = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (out_ready),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_valid (out_valid),
        .i_ready (in_ready),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        force_a;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!out_ready && n < 20) begin
            tick();
            n++;
        end
        ok = out_ready;
    endtask

    // Returns with #1 after the accepting edge.
    task automatic accept(input logic [15:0] va, input logic [15:0] vb,
                          input logic vc);
        bit ok;
        wait_ready(ok);
        check("ready_before_accept", 32'(ok), 32'd1);
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic release_result();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("idle_valid_low", 32'(out_valid), 32'd0);
        check("idle_ready_high", 32'(out_ready), 32'd1);
    endtask

    function automatic logic [17:0] model(input logic [15:0] ma,
                                          input logic [15:0] mb,
                                          input logic mc);
        logic [16:0] full;
        logic        sa;
        logic        sb;
        logic        ss;
        full = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
        sa = ma[15];
        sb = mb[15];
        ss = full[15];
        return {(sa == sb) && (ss != sa), full};
    endfunction

    initial begin
        int n;
        int seen;
        logic [15:0] held_sum;
        logic        held_cout;
        logic [17:0] ref_v;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[5] = '{16'h0FFF, 16'hF000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(out_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        for (int i = 0; i < 6; i++) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].cin);
            if (tbl[i].force_a) begin
                a = '0;
                b = '0;
                cin = 1'b0;
            end
            check("run_ready_low", 32'(out_ready), 32'd0);
            wait_valid(n);
            check("latency", 32'(n), 32'(LAT));
            check("vec_sum", 32'(sum), 32'(tbl[i].sum));
            check("vec_cout", 32'(cout), 32'(tbl[i].cout));
            check("vec_ovf", 32'(ovf), 32'(tbl[i].ovf));
            release_result();
        end

        // Backpressure: result must sit still while the consumer stalls.
        accept(16'hABCD, 16'h6543, 1'b0);
        wait_valid(n);
        check("bp_latency", 32'(n), 32'(LAT));
        held_sum = sum;
        held_cout = cout;
        check("bp_sum", 32'(held_sum), 32'h1110);
        check("bp_cout", 32'(held_cout), 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            a = 16'h1111;
            b = 16'h2222;
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(out_ready), 32'd0);
            check("bp_sum_hold", 32'(sum), 32'(held_sum));
            check("bp_cout_hold", 32'(cout), 32'(held_cout));
        end
        in_valid = 1'b0;
        release_result();
        check("bp_sum_after", 32'(sum), 32'(held_sum));

        // Reset in the second RUN cycle discards the operation.
        accept(16'h00FF, 16'h00FF, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(out_ready), 32'd1);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);

        // Random traffic with gaps and stray strobes.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_v = model(ra, rb, rc);
            accept(ra, rb, rc);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < LAT - 1; k++) tick();
            in_valid = 1'b0;
            in_ready = 1'b0;
            wait_valid(n);
            check("rnd_valid", 32'(out_valid), 32'd1);
            repeat ($urandom_range(0, 3)) tick();
            check("rnd_sum", 32'(sum), 32'(ref_v[15:0]));
            check("rnd_cout", 32'(cout), 32'(ref_v[16]));
            check("rnd_ovf", 32'(ovf), 32'(ref_v[17]));
            release_result();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
